csr_unit: RTL and testbench
===========================

CSR_UNIT -- requirements
Module: csr_unit

Interface
REQ-001 SHALL provide parameters as follows:
- XLEN, 32, data width; only 32 and 64 are legal.
- MISA_VAL, 32'h4000_0100, value returned by misa.
- MVENDORID, 0, value returned by mvendorid.
- MARCHID, 0, value returned by marchid.
- MIMPID, 0, value returned by mimpid.
- MHARTID, 0, value returned by mhartid.

REQ-002 SHALL provide ports (name, direction, width, meaning) as follows:
- clock, in, 1, single clock; all state updates on its rising edge.
- reset, in, 1, synchronous, active-high.
- csr_req, in, 1, access valid.
- csr_addr, in, 12, CSR number.
- csr_op, in, 2, 00 read, 01 write, 10 set-bits, 11 clear-bits.
- csr_wdata, in, XLEN, operand.
- csr_rdata, out, XLEN, registered old value.
- csr_ack, out, 1, one-cycle completion pulse.
- csr_illegal, out, 1, valid with csr_ack.
- instret_inc, in, 1, one instruction retired this cycle.
- trap_req, in, 1, take trap this cycle.
- trap_cause, in, XLEN, cause to record.
- trap_pc, in, XLEN, faulting PC.
- mret_req, in, 1, return from trap.
- irq_ext, in, 1, external interrupt level (mip.MEIP).
- irq_timer, in, 1, timer interrupt level (mip.MTIP).
- irq_sw, in, 1, software interrupt level (mip.MSIP).
- mtvec_out, out, XLEN, current mtvec.
- mepc_out, out, XLEN, current mepc.
- irq_pending, out, 1, enabled interrupt pending.

Function
REQ-003 SHALL implement these CSRs:
- misa 0x301, RO.
- mvendorid 0xF11, RO.
- marchid 0xF12, RO.
- mimpid 0xF13, RO.
- mhartid 0xF14, RO.
- mstatus 0x300: only MIE[3], MPIE[7], MPP[12:11] held; other bits read 0.
- mie 0x304: bits 11, 7 and 3 writable.
- mtvec 0x305: bits [1:0] read 0.
- mcounteren 0x306.
- mcountinhibit 0x320: bits 0 (CY) and 2 (IR) writable.
- mepc 0x341: bits [1:0] read 0.
- mcause 0x342.
- mip 0x344: RO view of irq_ext/irq_timer/irq_sw at bits 11/7/3.
- mcycle 0xB00, minstret 0xB02.
- mcycleh 0xB80, minstreth 0xB82: XLEN=32 only.

REQ-004 SHALL have fixed access latency of 1 cycle:
- On a clock edge with csr_req=1, csr_ack is 1 for exactly the next cycle.
- csr_rdata = CSR value before the access.
- The write takes effect at that same edge.

REQ-005 SHALL compute the new value as: write = wdata; set = old | wdata; clear = old & ~wdata; then apply the field masks of REQ-003.

REQ-006 SHALL treat set/clear with csr_wdata=0 as a read (no write side effects).

REQ-007 SHALL flag csr_illegal=1, with csr_rdata=0 and no state change, when any of these holds:
- unknown address;
- mcycleh/minstreth accessed with XLEN=64;
- a write, or set/clear with nonzero wdata, to a RO CSR other than mip.

REQ-008 SHALL silently ignore writes to mip (no illegal flag).

REQ-009 SHALL run the 64-bit mcycle counter as follows:
- increments every cycle unless mcountinhibit.CY=1;
- wraps 2^64-1 -> 0;
- a CSR write to any part of it that cycle overrides the increment for that part.

REQ-010 SHALL run the 64-bit minstret counter as follows:
- increments when instret_inc=1 and mcountinhibit.IR=0;
- same wrap and override rules as mcycle.

REQ-011 SHALL carry from the low word into the high word (XLEN=32) in the same cycle, so a read never sees a torn increment.

REQ-012 SHALL, on trap_req, perform at that edge:
- mepc <= trap_pc & ~3;
- mcause <= trap_cause;
- MPIE <= MIE;
- MIE <= 0;
- MPP <= 2'b11.

REQ-013 SHALL, on mret_req (without trap_req), set MIE <= MPIE, MPIE <= 1, MPP <= 2'b11.

REQ-014 SHALL resolve simultaneous events with priority trap_req > mret_req > csr_req:
- A csr_req that loses produces csr_ack=0 and no state change; the requester retries.
- Counter increments are unaffected by the outcome.

REQ-015 SHALL drive irq_pending = mstatus.MIE & |(mie & mip) combinationally from registered state and inputs.

REQ-016 SHALL drive mtvec_out and mepc_out directly from the registers.

Reset
REQ-017 SHALL, with reset=1 at a clock edge:
- clear all writable CSRs and both counters to 0, except MPP = 2'b11;
- drive csr_ack=0, csr_illegal=0, csr_rdata=0.

REQ-018 SHALL give reset priority over trap_req, mret_req, csr_req and counter increments, including an access in flight, whose ack is suppressed.

REQ-019 SHALL make RO CSRs read their parameter values immediately after reset.

Verification
REQ-020 Reset then read 0x301 -> ack next cycle, rdata=32'h4000_0100, illegal=0.

REQ-021 Write 0x305 with 0x8000_0013, then read -> rdata 0x8000_0010. Set 0x300 with 0x8, then read -> 0x1808.

REQ-022 Write 0xF11 with 5 -> illegal=1, rdata=0. Read 0x7C0 -> illegal=1. Write 0x344 with 0xFFFF_FFFF -> illegal=0, mip unchanged.

REQ-023 Write mcycle=0xFFFF_FFFF, mcycleh=0 with CY enabled -> next cycle mcycleh reads 1 and mcycle wraps to 0. Set mcountinhibit=5 -> both counters hold.

REQ-024 MIE=1, mie=0x80, irq_timer=1 -> irq_pending=1. Then trap_req with trap_pc=0x103, cause=0x8000_0007, plus a concurrent csr write -> mepc=0x100, MIE=0, MPIE=1, irq_pending=0, csr_ack=0. Then mret_req -> MIE=1.

REQ-025 Assert reset in the same cycle as csr_req write to mtvec -> mtvec=0, csr_ack stays 0.

Source files
------------

// File: rtl/csr_unit.sv
// Machine-mode CSR file: one-cycle access port, 64-bit cycle/instret counters,
// trap entry and mret sequencing, and the enabled-interrupt summary.
module csr_unit #(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] MISA_VAL  = 'h4000_0100,
  parameter logic [XLEN-1:0] MVENDORID = '0,
  parameter logic [XLEN-1:0] MARCHID   = '0,
  parameter logic [XLEN-1:0] MIMPID    = '0,
  parameter logic [XLEN-1:0] MHARTID   = '0
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            csr_req,
  input  logic [11:0]     csr_addr,
  input  logic [1:0]      csr_op,
  input  logic [XLEN-1:0] csr_wdata,
  output logic [XLEN-1:0] csr_rdata,
  output logic            csr_ack,
  output logic            csr_illegal,
  input  logic            instret_inc,
  input  logic            trap_req,
  input  logic [XLEN-1:0] trap_cause,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            mret_req,
  input  logic            irq_ext,
  input  logic            irq_timer,
  input  logic            irq_sw,
  output logic [XLEN-1:0] mtvec_out,
  output logic [XLEN-1:0] mepc_out,
  output logic            irq_pending
);

  localparam logic [11:0] A_MSTATUS       = 12'h300;
  localparam logic [11:0] A_MISA          = 12'h301;
  localparam logic [11:0] A_MIE           = 12'h304;
  localparam logic [11:0] A_MTVEC         = 12'h305;
  localparam logic [11:0] A_MCOUNTEREN    = 12'h306;
  localparam logic [11:0] A_MCOUNTINHIBIT = 12'h320;
  localparam logic [11:0] A_MEPC          = 12'h341;
  localparam logic [11:0] A_MCAUSE        = 12'h342;
  localparam logic [11:0] A_MIP           = 12'h344;
  localparam logic [11:0] A_MCYCLE        = 12'hB00;
  localparam logic [11:0] A_MINSTRET      = 12'hB02;
  localparam logic [11:0] A_MCYCLEH       = 12'hB80;
  localparam logic [11:0] A_MINSTRETH     = 12'hB82;
  localparam logic [11:0] A_MVENDORID     = 12'hF11;
  localparam logic [11:0] A_MARCHID       = 12'hF12;
  localparam logic [11:0] A_MIMPID        = 12'hF13;
  localparam logic [11:0] A_MHARTID       = 12'hF14;

  localparam logic [XLEN-1:0] ALIGN_MASK = {{(XLEN-2){1'b1}}, 2'b00};

  function automatic logic [XLEN-1:0] apply_op(input logic [1:0]      op,
                                                input logic [XLEN-1:0] old,
                                                input logic [XLEN-1:0] operand);
    case (op)
      2'b01:   return operand;
      2'b10:   return old | operand;
      2'b11:   return old & ~operand;
      default: return old;
    endcase
  endfunction

  logic            mst_mie, mst_mpie;
  logic [1:0]      mst_mpp;
  logic            mie_meie, mie_mtie, mie_msie;
  logic [XLEN-1:0] mtvec_q, mepc_q, mcause_q, mcounteren_q;
  logic            inh_cy, inh_ir;
  logic [63:0]     mcycle_q, minstret_q;
  logic [63:0]     cycle_n, instret_n;

  logic [XLEN-1:0] rdata_p1;
  logic            ack_p1, illegal_p1;

  logic [XLEN-1:0] old_val, new_val;
  logic            known, read_only, modifies, illegal, accept, do_write;

  always_comb begin
    old_val   = '0;
    known     = 1'b1;
    read_only = 1'b0;
    case (csr_addr)
      A_MISA:      begin old_val = MISA_VAL;  read_only = 1'b1; end
      A_MVENDORID: begin old_val = MVENDORID; read_only = 1'b1; end
      A_MARCHID:   begin old_val = MARCHID;   read_only = 1'b1; end
      A_MIMPID:    begin old_val = MIMPID;    read_only = 1'b1; end
      A_MHARTID:   begin old_val = MHARTID;   read_only = 1'b1; end
      A_MSTATUS: begin
        old_val[3]     = mst_mie;
        old_val[7]     = mst_mpie;
        old_val[12:11] = mst_mpp;
      end
      A_MIE: begin
        old_val[11] = mie_meie;
        old_val[7]  = mie_mtie;
        old_val[3]  = mie_msie;
      end
      A_MTVEC:         old_val = mtvec_q;
      A_MCOUNTEREN:    old_val = mcounteren_q;
      A_MCOUNTINHIBIT: begin old_val[0] = inh_cy; old_val[2] = inh_ir; end
      A_MEPC:          old_val = mepc_q;
      A_MCAUSE:        old_val = mcause_q;
      // mip is a live view of the interrupt lines; writes are dropped, not faulted
      A_MIP: begin
        old_val[11] = irq_ext;
        old_val[7]  = irq_timer;
        old_val[3]  = irq_sw;
      end
      A_MCYCLE:    old_val = mcycle_q[XLEN-1:0];
      A_MINSTRET:  old_val = minstret_q[XLEN-1:0];
      A_MCYCLEH:   begin old_val[31:0] = mcycle_q[63:32];   known = (XLEN == 32); end
      A_MINSTRETH: begin old_val[31:0] = minstret_q[63:32]; known = (XLEN == 32); end
      default:     known = 1'b0;
    endcase

    modifies = (csr_op == 2'b01) || (csr_op[1] && (csr_wdata != '0));
    illegal  = !known || (read_only && modifies);
    accept   = csr_req && !trap_req && !mret_req;
    do_write = accept && !illegal && modifies;
    new_val  = apply_op(csr_op, old_val, csr_wdata);
  end

  // Counter next-state: a 64-bit add keeps the high word coherent with the low word.
  always_comb begin
    cycle_n   = mcycle_q + {63'd0, !inh_cy};
    instret_n = minstret_q + {63'd0, instret_inc && !inh_ir};
    if (do_write) begin
      case (csr_addr)
        A_MCYCLE:    cycle_n[XLEN-1:0]   = new_val;
        A_MCYCLEH:   cycle_n[63:32]      = new_val[31:0];
        A_MINSTRET:  instret_n[XLEN-1:0] = new_val;
        A_MINSTRETH: instret_n[63:32]    = new_val[31:0];
        default: ;
      endcase
    end
  end

  // Stage p1: registered access response and architectural state update.
  always_ff @(posedge clock) begin
    if (reset) begin
      ack_p1       <= 1'b0;
      illegal_p1   <= 1'b0;
      rdata_p1     <= '0;
      mst_mie      <= 1'b0;
      mst_mpie     <= 1'b0;
      mst_mpp      <= 2'b11;
      mie_meie     <= 1'b0;
      mie_mtie     <= 1'b0;
      mie_msie     <= 1'b0;
      mtvec_q      <= '0;
      mcounteren_q <= '0;
      inh_cy       <= 1'b0;
      inh_ir       <= 1'b0;
      mepc_q       <= '0;
      mcause_q     <= '0;
      mcycle_q     <= '0;
      minstret_q   <= '0;
    end else begin
      ack_p1     <= accept;
      illegal_p1 <= accept && illegal;
      rdata_p1   <= (accept && !illegal) ? old_val : '0;
      mcycle_q   <= cycle_n;
      minstret_q <= instret_n;
      if (trap_req) begin
        mepc_q   <= trap_pc & ALIGN_MASK;
        mcause_q <= trap_cause;
        mst_mpie <= mst_mie;
        mst_mie  <= 1'b0;
        mst_mpp  <= 2'b11;
      end else if (mret_req) begin
        mst_mie  <= mst_mpie;
        mst_mpie <= 1'b1;
        mst_mpp  <= 2'b11;
      end else if (do_write) begin
        case (csr_addr)
          A_MSTATUS: begin
            mst_mie  <= new_val[3];
            mst_mpie <= new_val[7];
            mst_mpp  <= new_val[12:11];
          end
          A_MIE: begin
            mie_meie <= new_val[11];
            mie_mtie <= new_val[7];
            mie_msie <= new_val[3];
          end
          A_MTVEC:         mtvec_q      <= new_val & ALIGN_MASK;
          A_MCOUNTEREN:    mcounteren_q <= new_val;
          A_MCOUNTINHIBIT: begin inh_cy <= new_val[0]; inh_ir <= new_val[2]; end
          A_MEPC:          mepc_q       <= new_val & ALIGN_MASK;
          A_MCAUSE:        mcause_q     <= new_val;
          default: ;
        endcase
      end
    end
  end

  assign csr_rdata   = rdata_p1;
  assign csr_ack     = ack_p1;
  assign csr_illegal = illegal_p1;
  assign mtvec_out   = mtvec_q;
  assign mepc_out    = mepc_q;
  assign irq_pending = mst_mie && ((mie_meie && irq_ext) ||
                                   (mie_mtie && irq_timer) ||
                                   (mie_msie && irq_sw));

endmodule

// File: tb/tb_csr_unit.sv
// Scoreboarded bench for csr_unit: directed scenarios followed by random traffic,
// checked against a table-driven reference model of the CSR file.
module tb_csr_unit;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset, csr_req, csr_ack, csr_illegal;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [31:0] csr_wdata, csr_rdata;
  logic        instret_inc, trap_req, mret_req;
  logic [31:0] trap_cause, trap_pc;
  logic        irq_ext, irq_timer, irq_sw, irq_pending;
  logic [31:0] mtvec_out, mepc_out;

  csr_unit #(.XLEN(32)) dut (
    .clock(clock), .reset(reset), .csr_req(csr_req), .csr_addr(csr_addr),
    .csr_op(csr_op), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
    .csr_ack(csr_ack), .csr_illegal(csr_illegal), .instret_inc(instret_inc),
    .trap_req(trap_req), .trap_cause(trap_cause), .trap_pc(trap_pc),
    .mret_req(mret_req), .irq_ext(irq_ext), .irq_timer(irq_timer),
    .irq_sw(irq_sw), .mtvec_out(mtvec_out), .mepc_out(mepc_out),
    .irq_pending(irq_pending)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [31:0] rdata;
    logic        ill;
  } exp_t;
  exp_t q[$];

  // Reference model: writable CSRs held as masked words, counters as 64-bit integers.
  bit [31:0] regs  [bit [11:0]];
  bit [31:0] wmask [bit [11:0]];
  bit [31:0] roval [bit [11:0]];
  bit [63:0] m_cyc, m_ins;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void m_reset();
    foreach (wmask[a]) regs[a] = 32'h0;
    regs[12'h300] = 32'h0000_1800;
    m_cyc = 64'd0;
    m_ins = 64'd0;
  endfunction

  function automatic bit [31:0] m_mip();
    return {20'b0, irq_ext, 3'b0, irq_timer, 3'b0, irq_sw, 3'b0};
  endfunction

  function automatic bit m_irq();
    bit [31:0] st;
    st = regs[12'h300];
    return st[3] && ((regs[12'h304] & m_mip()) != 32'h0);
  endfunction

  function automatic void m_lookup(input bit [11:0] a, output bit [31:0] d,
                                   output bit known, output bit ro, output bit is_mip);
    known = 1'b1; ro = 1'b0; is_mip = 1'b0; d = 32'h0;
    if (roval.exists(a)) begin d = roval[a]; ro = 1'b1; end
    else if (regs.exists(a)) d = regs[a];
    else if (a == 12'h344) begin d = m_mip(); is_mip = 1'b1; end
    else if (a == 12'hB00) d = m_cyc[31:0];
    else if (a == 12'hB80) d = m_cyc[63:32];
    else if (a == 12'hB02) d = m_ins[31:0];
    else if (a == 12'hB82) d = m_ins[63:32];
    else known = 1'b0;
  endfunction

  // Advance the model across one rising edge using the currently driven inputs.
  function automatic void m_edge();
    bit [63:0] nc, ni;
    bit [31:0] old, nv, st;
    bit        known, ro, is_mip, modifies, ill;
    if (reset) begin
      m_reset();
      return;
    end
    st = regs[12'h320];
    nc = m_cyc + (st[0] ? 64'd0 : 64'd1);
    ni = m_ins + ((instret_inc && !st[2]) ? 64'd1 : 64'd0);
    st = regs[12'h300];
    if (trap_req) begin
      regs[12'h341] = trap_pc & ~32'h3;
      regs[12'h342] = trap_cause;
      regs[12'h300] = (st & ~32'h1888) | 32'h1800 | (st[3] ? 32'h80 : 32'h0);
    end else if (mret_req) begin
      regs[12'h300] = (st & ~32'h1888) | 32'h1880 | (st[7] ? 32'h8 : 32'h0);
    end else if (csr_req) begin
      m_lookup(csr_addr, old, known, ro, is_mip);
      modifies = (csr_op == 2'b01) || (csr_op[1] && csr_wdata != 32'h0);
      ill = !known || (ro && modifies);
      q.push_back('{cyc + 1, ill ? 32'h0 : old, ill});
      if (!ill && modifies && !is_mip) begin
        case (csr_op)
          2'b01:   nv = csr_wdata;
          2'b10:   nv = old | csr_wdata;
          default: nv = old & ~csr_wdata;
        endcase
        if (wmask.exists(csr_addr)) regs[csr_addr] = nv & wmask[csr_addr];
        else if (csr_addr == 12'hB00) nc[31:0]  = nv;
        else if (csr_addr == 12'hB80) nc[63:32] = nv;
        else if (csr_addr == 12'hB02) ni[31:0]  = nv;
        else if (csr_addr == 12'hB82) ni[63:32] = nv;
      end
    end
    m_cyc = nc;
    m_ins = ni;
  endfunction

  // Monitor: every ack must match the oldest expected response, and on time.
  always @(negedge clock) begin
    while (q.size() > 0 && q[0].due < cyc) begin
      n_tests++;
      n_fail++;
      $display("FAIL ack_missing: got no ack expected ack due at cycle %0d", q[0].due);
      void'(q.pop_front());
    end
    if (csr_ack === 1'b1) begin
      if (q.size() == 0 || q[0].due != cyc) begin
        n_tests++;
        n_fail++;
        $display("FAIL ack_unexpected: got ack=1 expected ack=0 (cycle %0d)", cyc);
      end else begin
        check("rdata", csr_rdata, q[0].rdata);
        check("illegal", {31'b0, csr_illegal}, {31'b0, q[0].ill});
        void'(q.pop_front());
      end
    end
  end

  task automatic tick();
    #1;
    check("irq_pending", {31'b0, irq_pending}, {31'b0, m_irq()});
    check("mtvec_out", mtvec_out, regs[12'h305]);
    check("mepc_out", mepc_out, regs[12'h341]);
    m_edge();
    @(posedge clock);
    #1;
  endtask

  task automatic quiet();
    reset = 1'b0; csr_req = 1'b0; trap_req = 1'b0; mret_req = 1'b0; instret_inc = 1'b0;
  endtask

  task automatic acc(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    csr_req = 1'b1; csr_op = op; csr_addr = a; csr_wdata = d;
    tick();
    csr_req = 1'b0;
  endtask

  localparam logic [1:0] RD = 2'b00, WR = 2'b01, ST = 2'b10, CL = 2'b11;

  bit [11:0] addr_tab [20] = '{12'h300, 12'h301, 12'h304, 12'h305, 12'h306,
                               12'h320, 12'h341, 12'h342, 12'h344, 12'hB00,
                               12'hB02, 12'hB80, 12'hB82, 12'hF11, 12'hF12,
                               12'hF13, 12'hF14, 12'h7C0, 12'h000, 12'h340};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wmask[12'h300] = 32'h0000_1888;
    wmask[12'h304] = 32'h0000_0888;
    wmask[12'h305] = 32'hFFFF_FFFC;
    wmask[12'h306] = 32'hFFFF_FFFF;
    wmask[12'h320] = 32'h0000_0005;
    wmask[12'h341] = 32'hFFFF_FFFC;
    wmask[12'h342] = 32'hFFFF_FFFF;
    roval[12'h301] = 32'h4000_0100;
    roval[12'hF11] = 32'h0;
    roval[12'hF12] = 32'h0;
    roval[12'hF13] = 32'h0;
    roval[12'hF14] = 32'h0;
    m_reset();

    quiet();
    reset = 1'b1; csr_addr = 12'h0; csr_op = RD; csr_wdata = 32'h0;
    trap_cause = 32'h0; trap_pc = 32'h0; irq_ext = 1'b0; irq_timer = 1'b0; irq_sw = 1'b0;
    @(posedge clock);
    #1;
    check("reset_ack", {31'b0, csr_ack}, 32'h0);
    check("reset_illegal", {31'b0, csr_illegal}, 32'h0);
    check("reset_rdata", csr_rdata, 32'h0);
    check("reset_mtvec", mtvec_out, 32'h0);
    check("reset_mepc", mepc_out, 32'h0);
    reset = 1'b0;

    acc(RD, 12'h301, 32'h0);
    acc(WR, 12'h305, 32'h8000_0013);
    check("mtvec_aligned", mtvec_out, 32'h8000_0010);
    acc(RD, 12'h305, 32'h0);
    acc(ST, 12'h300, 32'h8);
    acc(RD, 12'h300, 32'h0);

    acc(WR, 12'hF11, 32'h5);
    acc(RD, 12'h7C0, 32'h0);
    acc(WR, 12'h344, 32'hFFFF_FFFF);
    acc(RD, 12'h344, 32'h0);
    acc(ST, 12'h301, 32'h0);

    acc(WR, 12'hB80, 32'h0);
    acc(WR, 12'hB00, 32'hFFFF_FFFF);
    tick();
    acc(RD, 12'hB80, 32'h0);
    acc(RD, 12'hB00, 32'h0);
    acc(ST, 12'h320, 32'h5);
    instret_inc = 1'b1;
    acc(RD, 12'hB00, 32'h0);
    acc(RD, 12'hB00, 32'h0);
    acc(RD, 12'hB02, 32'h0);
    acc(RD, 12'hB02, 32'h0);
    instret_inc = 1'b0;
    acc(WR, 12'h320, 32'h0);

    acc(WR, 12'h304, 32'h80);
    irq_timer = 1'b1;
    #1;
    check("irq_pending_set", {31'b0, irq_pending}, 32'h1);
    trap_req = 1'b1; trap_pc = 32'h103; trap_cause = 32'h8000_0007;
    csr_req = 1'b1; csr_op = WR; csr_addr = 12'h305; csr_wdata = 32'h44;
    tick();
    trap_req = 1'b0; csr_req = 1'b0;
    check("trap_ack", {31'b0, csr_ack}, 32'h0);
    check("trap_mepc", mepc_out, 32'h100);
    check("trap_irq", {31'b0, irq_pending}, 32'h0);
    acc(RD, 12'h300, 32'h0);
    acc(RD, 12'h342, 32'h0);
    mret_req = 1'b1;
    tick();
    mret_req = 1'b0;
    acc(RD, 12'h300, 32'h0);
    irq_timer = 1'b0;

    reset = 1'b1;
    acc(WR, 12'h305, 32'h1234_5678);
    reset = 1'b0;
    check("reset_race_ack", {31'b0, csr_ack}, 32'h0);
    check("reset_race_mtvec", mtvec_out, 32'h0);
    acc(RD, 12'h301, 32'h0);

    for (int i = 0; i < 500; i++) begin
      reset       = ($urandom_range(0, 99) < 2);
      csr_req     = ($urandom_range(0, 99) < 60);
      csr_addr    = addr_tab[$urandom_range(0, 19)];
      if ($urandom_range(0, 9) == 0) csr_addr = 12'($urandom);
      csr_op      = 2'($urandom);
      csr_wdata   = ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom;
      trap_req    = ($urandom_range(0, 99) < 5);
      mret_req    = ($urandom_range(0, 99) < 6);
      trap_cause  = $urandom;
      trap_pc     = $urandom;
      instret_inc = 1'($urandom);
      irq_ext     = 1'($urandom);
      irq_timer   = 1'($urandom);
      irq_sw      = 1'($urandom);
      tick();
    end

    quiet();
    acc(RD, 12'hB80, 32'h0);
    acc(RD, 12'hB82, 32'h0);
    tick();
    tick();
    tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
